// File: rtl/fifo_access_ctrl_pkg.sv
// Shared types and default sizing for the FIFO access controller.
package fifo_ctrl_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

    // Read-side sequencer states
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_HOLD = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_access_ctrl_if.sv
// Bus bundle between the access controller and its requesters, FIFO and sink.
interface fifo_access_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int CNT_W   = FIFO_CNT_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_grant;
    logic                      fifo_wr;
    logic [DATA_W-1:0]         fifo_wdata;
    logic                      fifo_full;
    logic                      fifo_threshold;
    logic                      fifo_rd;
    logic [DATA_W-1:0]         fifo_rdata;
    logic                      fifo_empty;
    logic                      fifo_overflow;
    logic                      fifo_underflow;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_ready;
    logic [CNT_W-1:0]          level;
    logic                      err_ovf;
    logic                      err_udf;

    // Controller side
    modport master (
        input  req_valid, req_data, fifo_full, fifo_threshold, fifo_rdata,
               fifo_empty, fifo_overflow, fifo_underflow, out_ready,
        output req_grant, fifo_wr, fifo_wdata, fifo_rd, out_valid, out_data,
               level, err_ovf, err_udf
    );

    // Requesters, FIFO memory and downstream sink
    modport slave (
        output req_valid, req_data, fifo_full, fifo_threshold, fifo_rdata,
               fifo_empty, fifo_overflow, fifo_underflow, out_ready,
        input  req_grant, fifo_wr, fifo_wdata, fifo_rd, out_valid, out_data,
               level, err_ovf, err_udf
    );

endinterface

// File: rtl/fifo_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter with a lock-to-requester-0 override.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               enable,
    input  logic               lock0,
    output logic [NUM_REQ-1:0] grant
);

    // Grant the first requester after the last winner, wrapping around
    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (enable) begin
            if (lock0) begin
                grant[0] = req[0];
            end else begin
                for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                    idx = (32'(ptr) + off) % 32'(NUM_REQ);
                    if (!found && req[idx]) begin
                        grant[idx] = 1'b1;
                        found      = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Write arbiter, occupancy tracker and read sequencer in front of the shared FIFO.
module fifo_access_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int DEPTH   = FIFO_DEPTH,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input logic               clk,
    input logic               rst_n,
    fifo_access_ctrl_if.master bus
);

    localparam int               PTR_W   = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   level_q;
    rd_state_e          rd_state;
    logic               space;
    logic               accept;
    logic               rd_issue;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_data;

    // Grants are held off during reset so nothing is offered that cannot be taken
    assign space = rst_n && (level_q < LVL_MAX) && !bus.fifo_full;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req    (bus.req_valid),
        .ptr    (rr_ptr),
        .enable (space),
        .lock0  (bus.fifo_threshold),
        .grant  (grant)
    );

    assign bus.req_grant = grant;
    assign accept        = |(grant & bus.req_valid);
    assign bus.level     = level_q;

    // Read is issued only when the FIFO has data, so underflow is never caused here
    assign rd_issue = !bus.fifo_empty &&
                      ((rd_state == R_IDLE) || ((rd_state == R_HOLD) && bus.out_ready));

    // Encode the one-hot grant into the winner index and its data word
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx  = PTR_W'(i);
                win_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register the accepted word as a one-cycle write strobe and advance the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fifo_wr    <= 1'b0;
            bus.fifo_wdata <= '0;
            rr_ptr         <= PTR_RST;
        end else begin
            bus.fifo_wr <= accept;
            if (accept) begin
                bus.fifo_wdata <= win_data;
                rr_ptr         <= win_idx;
            end
        end
    end

    // Occupancy: accepted words not yet read, clamped to 0..DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else if (accept && !rd_issue && (level_q != LVL_MAX)) begin
            level_q <= level_q + CNT_W'(1);
        end else if (rd_issue && !accept && (level_q != '0)) begin
            level_q <= level_q - CNT_W'(1);
        end
    end

    // Read sequencer: strobe the FIFO, capture the word, hold it until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state      <= R_IDLE;
            bus.fifo_rd   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            bus.fifo_rd <= rd_issue;
            case (rd_state)
                R_IDLE: begin
                    if (!bus.fifo_empty) rd_state <= R_WAIT;
                end
                R_WAIT: begin
                    bus.out_data  <= bus.fifo_rdata;
                    bus.out_valid <= 1'b1;
                    rd_state      <= R_HOLD;
                end
                R_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        rd_state      <= bus.fifo_empty ? R_IDLE : R_WAIT;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Sticky FIFO error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_ovf <= 1'b0;
            bus.err_udf <= 1'b0;
        end else begin
            bus.err_ovf <= bus.err_ovf | bus.fifo_overflow;
            bus.err_udf <= bus.err_udf | bus.fifo_underflow;
        end
    end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Randomised scoreboard bench for fifo_access_ctrl with a behavioural FIFO memory.
module tb_fifo_access_ctrl;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int D  = 16;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic full_force, ovf_force, udf_force;

    int checks = 0;
    int errors = 0;

    fifo_access_ctrl_if #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) bus ();

    fifo_access_ctrl #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(D), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural FIFO memory: show-ahead head word, pops on fifo_rd
    logic [DW-1:0] mem [D];
    int unsigned   wp, rp, fcnt;
    assign bus.fifo_empty     = (fcnt == 0);
    assign bus.fifo_full      = (fcnt == D) || full_force;
    assign bus.fifo_rdata     = mem[rp];
    assign bus.fifo_overflow  = ovf_force;
    assign bus.fifo_underflow = udf_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp   <= 0;
            rp   <= 0;
            fcnt <= 0;
        end else begin
            if (bus.fifo_wr) begin
                chk("fifo_space_on_write", 32'(fcnt < D), 1);
                mem[wp] <= bus.fifo_wdata;
                wp      <= (wp + 1) % D;
            end
            if (bus.fifo_rd) rp <= (rp + 1) % D;
            fcnt <= fcnt + (bus.fifo_wr ? 1 : 0) - (bus.fifo_rd ? 1 : 0);
        end
    end

    // Reference model state
    logic [DW-1:0] exp_q [$];
    int            rr_m, acc_m, rd_m;
    logic          eovf_m, eudf_m, wr_due;
    logic [DW-1:0] wr_due_data;

    // Predictor: reset values, level, write latency, expected grant
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_grant", 32'(bus.req_grant), 0);
            chk("rst_fifo_wr", 32'(bus.fifo_wr), 0);
            chk("rst_fifo_rd", 32'(bus.fifo_rd), 0);
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_out_data", 32'(bus.out_data), 0);
            chk("rst_fifo_wdata", 32'(bus.fifo_wdata), 0);
            chk("rst_level", 32'(bus.level), 0);
            chk("rst_err", {bus.err_ovf, bus.err_udf}, 0);
            rr_m   = N - 1;
            acc_m  = 0;
            rd_m   = 0;
            eovf_m = 1'b0;
            eudf_m = 1'b0;
            wr_due = 1'b0;
            exp_q.delete();
        end else begin
            int lvl_m, best, bestd, d;
            logic [N-1:0] egrant;
            if (bus.fifo_rd) rd_m++;
            lvl_m = acc_m - rd_m;
            chk("level", 32'(bus.level), 32'(lvl_m));
            chk("err_ovf", 32'(bus.err_ovf), 32'(eovf_m));
            chk("err_udf", 32'(bus.err_udf), 32'(eudf_m));
            chk("fifo_wr", 32'(bus.fifo_wr), 32'(wr_due));
            if (wr_due) chk("fifo_wdata", 32'(bus.fifo_wdata), 32'(wr_due_data));
            // winner = valid requester at smallest distance after the last winner
            best  = -1;
            bestd = N;
            if (lvl_m < D && !bus.fifo_full) begin
                if (bus.fifo_threshold) begin
                    if (bus.req_valid[0]) best = 0;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        d = (i + 2 * N - rr_m - 1) % N;
                        if (bus.req_valid[i] && d < bestd) begin
                            bestd = d;
                            best  = i;
                        end
                    end
                end
            end
            egrant = '0;
            if (best >= 0) egrant[best] = 1'b1;
            chk("req_grant", 32'(bus.req_grant), 32'(egrant));
            wr_due = 1'b0;
            if (best >= 0) begin
                acc_m++;
                rr_m        = best;
                wr_due      = 1'b1;
                wr_due_data = bus.req_data[best*DW +: DW];
                exp_q.push_back(bus.req_data[best*DW +: DW]);
            end
            if (bus.fifo_overflow)  eovf_m = 1'b1;
            if (bus.fifo_underflow) eudf_m = 1'b1;
        end
    end

    // Monitor: output stream against scoreboard, hold stability, read safety
    logic          hold_prev;
    logic [DW-1:0] held_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (bus.fifo_rd) chk("rd_while_empty", 32'(bus.fifo_empty), 0);
            if (hold_prev) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_data", 32'(bus.out_data), 32'(held_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
        end
    end

    // Stimulus policy
    logic [N-1:0] en_mask;
    int unsigned  vpct, thr_pct, full_pct;
    int           ready_mode;
    logic         rdy_fixed;
    bit           seq_mode;
    int unsigned  seq_next, seq_last;

    // Requesters hold word until granted, then optionally present a new one
    task automatic refill(input logic [N-1:0] taken);
        for (int i = 0; i < N; i++) begin
            if (taken[i] || !bus.req_valid[i]) begin
                if (seq_mode) begin
                    if (i == 2 && seq_next <= seq_last) begin
                        bus.req_valid[i]         = 1'b1;
                        bus.req_data[i*DW +: DW] = 8'(seq_next);
                        seq_next++;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if (en_mask[i] && $urandom_range(99) < vpct) begin
                    bus.req_valid[i]         = 1'b1;
                    bus.req_data[i*DW +: DW] = 8'($urandom);
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle_tail(input logic [N-1:0] taken);
        @(posedge clk);
        #2;
        refill(taken);
        case (ready_mode)
            0:       bus.out_ready = rdy_fixed;
            1:       bus.out_ready = !bus.out_ready;
            default: bus.out_ready = 1'($urandom_range(1));
        endcase
        bus.fifo_threshold = ($urandom_range(99) < thr_pct);
        full_force         = ($urandom_range(99) < full_pct);
    endtask

    task automatic step(input int n);
        logic [N-1:0] taken;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            taken = bus.req_valid & bus.req_grant;
            cycle_tail(taken);
        end
    endtask

    task automatic step_chk(input string name, input logic [N-1:0] exp);
        logic [N-1:0] taken;
        @(negedge clk);
        chk(name, 32'(bus.req_grant), 32'(exp));
        taken = bus.req_valid & bus.req_grant;
        cycle_tail(taken);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n          = 0;
        vpct       = 0;
        thr_pct    = 0;
        full_pct   = 0;
        ready_mode = (ready_mode == 1) ? 1 : 0;
        rdy_fixed  = 1'b1;
        while ((exp_q.size() != 0 || bus.req_valid != '0) && n < budget) begin
            step(1);
            n++;
        end
        chk({name, "_timeout"}, 32'(n < budget), 1);
        step(4);
        chk({name, "_level"}, 32'(bus.level), 0);
        chk({name, "_out_valid"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        rst_n              = 1'b0;
        full_force         = 1'b0;
        ovf_force          = 1'b0;
        udf_force          = 1'b0;
        bus.req_valid      = '0;
        bus.req_data       = '0;
        bus.fifo_threshold = 1'b0;
        bus.out_ready      = 1'b0;
        en_mask            = '1;
        vpct               = 100;
        thr_pct            = 0;
        full_pct           = 0;
        ready_mode         = 0;
        rdy_fixed          = 1'b1;
        seq_mode           = 1'b0;
        seq_next           = 0;
        seq_last           = 0;

        // Reset with all requesters asserting, then rotation from requester 0
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = 1'b1;
            bus.req_data[i*DW +: DW] = 8'($urandom);
        end
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step_chk("rr_first", 4'b0001);
        step_chk("rr_second", 4'b0010);
        step_chk("rr_third", 4'b0100);
        step_chk("rr_fourth", 4'b1000);
        step_chk("rr_wrap", 4'b0001);
        drain("drain_rr", 300);

        // Single requester fills the FIFO against a stalled sink
        seq_mode   = 1'b1;
        seq_next   = 1;
        seq_last   = 8'h12;
        ready_mode = 0;
        rdy_fixed  = 1'b0;
        step(40);
        chk("stall_level", 32'(bus.level), D);
        chk("stall_pending", 32'(bus.req_valid), 32'(4'b0100));
        chk("stall_no_grant", 32'(bus.req_grant), 0);
        chk("stall_out_valid", 32'(bus.out_valid), 1);
        chk("stall_out_data", 32'(bus.out_data), 1);
        chk("stall_err_ovf", 32'(bus.err_ovf), 0);
        drain("drain_seq", 300);
        chk("seq_all_sent", seq_next, 8'h13);
        seq_mode = 1'b0;

        // Priority lock: only requester 0 may win
        bus.fifo_threshold = 1'b1;
        thr_pct            = 100;
        en_mask            = 4'b1110;
        vpct               = 100;
        step(1);
        step_chk("lock_block", 4'b0000);
        step_chk("lock_block2", 4'b0000);
        en_mask = 4'b1111;
        step(1);
        step_chk("lock_grant0", 4'b0001);
        step_chk("lock_grant0_again", 4'b0001);
        drain("drain_lock", 300);

        // Fill, then drain with out_ready toggling every cycle
        en_mask    = '1;
        vpct       = 70;
        ready_mode = 0;
        rdy_fixed  = 1'b0;
        step(30);
        ready_mode = 1;
        drain("drain_toggle", 400);
        ready_mode = 0;

        // Random traffic with an overflow pulse and an underflow pulse
        vpct       = 60;
        ready_mode = 2;
        thr_pct    = 15;
        full_pct   = 10;
        step(150);
        ovf_force = 1'b1;
        step(1);
        ovf_force = 1'b0;
        step(100);
        udf_force = 1'b1;
        step(1);
        udf_force = 1'b0;
        step(100);
        chk("sticky_ovf", 32'(bus.err_ovf), 1);
        chk("sticky_udf", 32'(bus.err_udf), 1);

        // Asynchronous reset in the middle of a drain
        vpct       = 100;
        thr_pct    = 0;
        full_pct   = 0;
        ready_mode = 0;
        rdy_fixed  = 1'b0;
        begin
            int n;
            n = 0;
            while (!bus.out_valid && n < 100) begin
                step(1);
                n++;
            end
            chk("wait_out_valid", 32'(bus.out_valid), 1);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 0);
        chk("async_level", 32'(bus.level), 0);
        chk("async_err_ovf", 32'(bus.err_ovf), 0);
        chk("async_fifo_wr", 32'(bus.fifo_wr), 0);
        step(2);
        rst_n = 1'b1;

        // Post-reset traffic and final drain
        vpct       = 50;
        ready_mode = 2;
        step(120);
        drain("drain_final", 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
